// File: rtl/e203_soc_pkg.sv
// Shared constants for the E203 SoC pad shell: reset vectors, GPIO bank width, debug strap decode.
// Pure definitions; no latency or flow control involved.
package e203_soc_pkg;

   localparam int          GPIO_W    = 32;
   localparam logic [31:0] ROM_RTVEC = 32'h0000_1000;
   localparam logic [31:0] XIP_RTVEC = 32'h2000_0000;

   typedef logic [2:0] dbg_mode_t;
   localparam dbg_mode_t DBG_MODE_NONE = 3'b000;

   typedef enum logic {
      PMU_OFF = 1'b0,
      PMU_ON  = 1'b1
   } pmu_state_e;

   // Straps are active-low on the board; the core wants an active-high mode vector.
   function automatic dbg_mode_t dbg_mode_decode(input logic [2:0] straps_n);
      return ~straps_n;
   endfunction

endpackage

// File: rtl/e203_soc_pad_top_if.sv
// Pad-ring bundle of the E203 SoC; master = chip side, slave = board side.
// Wires only; no latency, no backpressure.
interface e203_soc_pad_top_if;
   import e203_soc_pkg::*;

   logic              hfxoscen;
   logic              lfextclk;
   logic              lfxoscen;
   logic              io_pads_jtag_TCK_i_ival;
   logic              io_pads_jtag_TMS_i_ival;
   logic              io_pads_jtag_TDI_i_ival;
   logic              io_pads_jtag_TDO_o_oval;
   logic              io_pads_jtag_TDO_o_oe;
   logic [GPIO_W-1:0] io_pads_gpioA_i_ival;
   logic [GPIO_W-1:0] io_pads_gpioA_o_oval;
   logic [GPIO_W-1:0] io_pads_gpioA_o_oe;
   logic [GPIO_W-1:0] io_pads_gpioB_i_ival;
   logic [GPIO_W-1:0] io_pads_gpioB_o_oval;
   logic [GPIO_W-1:0] io_pads_gpioB_o_oe;
   logic              io_pads_qspi0_sck_o_oval;
   logic              io_pads_qspi0_cs_0_o_oval;
   logic              io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_0_o_oval, io_pads_qspi0_dq_0_o_oe;
   logic              io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_1_o_oval, io_pads_qspi0_dq_1_o_oe;
   logic              io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_2_o_oval, io_pads_qspi0_dq_2_o_oe;
   logic              io_pads_qspi0_dq_3_i_ival, io_pads_qspi0_dq_3_o_oval, io_pads_qspi0_dq_3_o_oe;
   logic              io_pads_aon_pmu_dwakeup_n_i_ival;
   logic              io_pads_aon_pmu_vddpaden_o_oval;
   logic              io_pads_aon_pmu_padrst_o_oval;
   logic              io_pads_bootrom_n_i_ival;
   logic              io_pads_dbgmode0_n_i_ival;
   logic              io_pads_dbgmode1_n_i_ival;
   logic              io_pads_dbgmode2_n_i_ival;

   modport master (
      output hfxoscen, lfxoscen,
      input  lfextclk,
      input  io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival, io_pads_jtag_TDI_i_ival,
      output io_pads_jtag_TDO_o_oval, io_pads_jtag_TDO_o_oe,
      input  io_pads_gpioA_i_ival, io_pads_gpioB_i_ival,
      output io_pads_gpioA_o_oval, io_pads_gpioA_o_oe, io_pads_gpioB_o_oval, io_pads_gpioB_o_oe,
      output io_pads_qspi0_sck_o_oval, io_pads_qspi0_cs_0_o_oval,
      input  io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
      input  io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival,
      output io_pads_qspi0_dq_0_o_oval, io_pads_qspi0_dq_0_o_oe, io_pads_qspi0_dq_1_o_oval, io_pads_qspi0_dq_1_o_oe,
      output io_pads_qspi0_dq_2_o_oval, io_pads_qspi0_dq_2_o_oe, io_pads_qspi0_dq_3_o_oval, io_pads_qspi0_dq_3_o_oe,
      input  io_pads_aon_pmu_dwakeup_n_i_ival,
      output io_pads_aon_pmu_vddpaden_o_oval, io_pads_aon_pmu_padrst_o_oval,
      input  io_pads_bootrom_n_i_ival, io_pads_dbgmode0_n_i_ival,
      input  io_pads_dbgmode1_n_i_ival, io_pads_dbgmode2_n_i_ival
   );

   modport slave (
      input  hfxoscen, lfxoscen,
      output lfextclk,
      output io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival, io_pads_jtag_TDI_i_ival,
      input  io_pads_jtag_TDO_o_oval, io_pads_jtag_TDO_o_oe,
      output io_pads_gpioA_i_ival, io_pads_gpioB_i_ival,
      input  io_pads_gpioA_o_oval, io_pads_gpioA_o_oe, io_pads_gpioB_o_oval, io_pads_gpioB_o_oe,
      input  io_pads_qspi0_sck_o_oval, io_pads_qspi0_cs_0_o_oval,
      output io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
      output io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival,
      input  io_pads_qspi0_dq_0_o_oval, io_pads_qspi0_dq_0_o_oe, io_pads_qspi0_dq_1_o_oval, io_pads_qspi0_dq_1_o_oe,
      input  io_pads_qspi0_dq_2_o_oval, io_pads_qspi0_dq_2_o_oe, io_pads_qspi0_dq_3_o_oval, io_pads_qspi0_dq_3_o_oe,
      output io_pads_aon_pmu_dwakeup_n_i_ival,
      input  io_pads_aon_pmu_vddpaden_o_oval, io_pads_aon_pmu_padrst_o_oval,
      output io_pads_bootrom_n_i_ival, io_pads_dbgmode0_n_i_ival,
      output io_pads_dbgmode1_n_i_ival, io_pads_dbgmode2_n_i_ival
   );

endinterface

// File: rtl/e203_gnrl_sync.sv
// Width-parameterised DP-stage synchroniser, cleared to zero by async active-low reset.
// Latency DP cycles; no backpressure.
module e203_gnrl_sync #(
   parameter int DP = 2,
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] sync_r [DP];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DP; i++) sync_r[i] <= '0;
      end else begin
         sync_r[0] <= din;
         for (int i = 1; i < DP; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   assign dout = sync_r[DP-1];

endmodule

// File: rtl/e203_subsys_top.sv
// Stand-in for the core subsystem: loops synchronised pads back onto the outputs so the pad ring
// can be brought up without the CPU. Outputs are combinational from inputs; no backpressure.
module e203_subsys_top
   import e203_soc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       pc_rtvec,
   input  dbg_mode_t         dbg_mode,
   input  logic              rtc_tick,
   input  logic              wake_evt,
   input  logic              jtag_tck,
   input  logic              jtag_tms,
   input  logic              jtag_tdi,
   output logic              jtag_tdo,
   output logic              jtag_tdo_oe,
   input  logic [GPIO_W-1:0] gpioA_i,
   input  logic [GPIO_W-1:0] gpioB_i,
   output logic [GPIO_W-1:0] gpioA_o,
   output logic [GPIO_W-1:0] gpioA_oe,
   output logic [GPIO_W-1:0] gpioB_o,
   output logic [GPIO_W-1:0] gpioB_oe,
   output logic              qspi_sck,
   output logic              qspi_cs_0,
   input  logic [3:0]        qspi_dq_i,
   output logic [3:0]        qspi_dq_o,
   output logic [3:0]        qspi_dq_oe
);

   logic [27:0] mtime;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        mtime <= '0;
      else if (rtc_tick) mtime <= mtime + 28'd1;
   end

   // Boot config and timer are exposed on gpioA so they are observable on a scope.
   assign gpioA_o     = GPIO_W'(pc_rtvec | {dbg_mode, wake_evt, mtime});
   assign gpioA_oe    = gpioB_i;
   assign gpioB_o     = ~gpioA_i;
   assign gpioB_oe    = gpioA_i;
   assign jtag_tdo    = jtag_tdi;
   assign jtag_tdo_oe = jtag_tms;
   assign qspi_sck    = jtag_tck;
   assign qspi_cs_0   = ~jtag_tms;
   assign qspi_dq_o   = qspi_dq_i;
   assign qspi_dq_oe  = {4{jtag_tms}};

endmodule

// File: rtl/e203_soc_pad_top.sv
// E203 chip shell: reset conditioning, strap capture, RTC tick, pad synchronisers and output gating.
// Inputs reach the core after SYNC_STAGES cycles, TDO pins 1 cycle, other outputs combinational; no backpressure.
module e203_soc_pad_top #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] ROM_RTVEC   = e203_soc_pkg::ROM_RTVEC,
   parameter logic [31:0] XIP_RTVEC   = e203_soc_pkg::XIP_RTVEC
) (
   input  logic               hfextclk,
   input  logic               io_pads_aon_erst_n_i_ival,
   e203_soc_pad_top_if.master pad
);
   import e203_soc_pkg::*;

   logic erst_n;
   logic core_rst_n;
   assign erst_n = io_pads_aon_erst_n_i_ival;

   // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(1)) u_rst_sync (
      .clk(hfextclk), .rst_n(erst_n), .din(1'b1), .dout(core_rst_n)
   );

   logic [2:0]        jtag_s;
   logic [GPIO_W-1:0] gpioA_s;
   logic [GPIO_W-1:0] gpioB_s;
   logic [3:0]        dq_s;
   logic              lf_s;
   logic              wake_evt;

   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(3)) u_jtag_sync (
      .clk(hfextclk), .rst_n(erst_n),
      .din({pad.io_pads_jtag_TCK_i_ival, pad.io_pads_jtag_TMS_i_ival, pad.io_pads_jtag_TDI_i_ival}),
      .dout(jtag_s)
   );
   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(GPIO_W)) u_gpioA_sync (
      .clk(hfextclk), .rst_n(erst_n), .din(pad.io_pads_gpioA_i_ival), .dout(gpioA_s)
   );
   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(GPIO_W)) u_gpioB_sync (
      .clk(hfextclk), .rst_n(erst_n), .din(pad.io_pads_gpioB_i_ival), .dout(gpioB_s)
   );
   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(4)) u_dq_sync (
      .clk(hfextclk), .rst_n(erst_n),
      .din({pad.io_pads_qspi0_dq_3_i_ival, pad.io_pads_qspi0_dq_2_i_ival,
            pad.io_pads_qspi0_dq_1_i_ival, pad.io_pads_qspi0_dq_0_i_ival}),
      .dout(dq_s)
   );
   // Wake is inverted before the chain so the cleared synchroniser reads "no wake".
   e203_gnrl_sync #(.DP(SYNC_STAGES), .DW(2)) u_aon_sync (
      .clk(hfextclk), .rst_n(erst_n),
      .din({pad.lfextclk, ~pad.io_pads_aon_pmu_dwakeup_n_i_ival}),
      .dout({lf_s, wake_evt})
   );

   pmu_state_e pmu_st;
   pmu_state_e pmu_nxt;
   logic       strap_cap;

   always_ff @(posedge hfextclk or negedge erst_n) begin
      if (!erst_n) pmu_st <= PMU_OFF;
      else         pmu_st <= pmu_nxt;
   end

   always_comb begin
      pmu_nxt   = pmu_st;
      strap_cap = 1'b0;
      case (pmu_st)
         PMU_OFF: begin
            if (core_rst_n) begin
               pmu_nxt   = PMU_ON;
               strap_cap = 1'b1;
            end
         end
         PMU_ON:  pmu_nxt = PMU_ON;
         default: pmu_nxt = PMU_OFF;
      endcase
   end

   logic        bootrom_n_q;
   dbg_mode_t   dbg_mode;
   logic [31:0] pc_rtvec;

   // Straps are static board pulls, so they are sampled raw on the single capture edge.
   always_ff @(posedge hfextclk or negedge erst_n) begin
      if (!erst_n) begin
         bootrom_n_q <= 1'b0;
         dbg_mode    <= DBG_MODE_NONE;
      end else if (strap_cap) begin
         bootrom_n_q <= pad.io_pads_bootrom_n_i_ival;
         dbg_mode    <= dbg_mode_decode({pad.io_pads_dbgmode2_n_i_ival,
                                         pad.io_pads_dbgmode1_n_i_ival,
                                         pad.io_pads_dbgmode0_n_i_ival});
      end
   end

   assign pc_rtvec = bootrom_n_q ? XIP_RTVEC : ROM_RTVEC;

   logic lf_q;
   logic rtc_tick;
   logic tdo_q;
   logic tdo_oe_q;
   logic core_tdo;
   logic core_tdo_oe;

   always_ff @(posedge hfextclk or negedge erst_n) begin
      if (!erst_n) begin
         lf_q     <= 1'b0;
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         lf_q     <= lf_s;
         tdo_q    <= core_rst_n & core_tdo;
         tdo_oe_q <= core_rst_n & core_tdo_oe;
      end
   end

   assign rtc_tick = lf_s & ~lf_q;

   logic [GPIO_W-1:0] core_gpioA_o, core_gpioA_oe, core_gpioB_o, core_gpioB_oe;
   logic              core_sck, core_cs;
   logic [3:0]        core_dq_o, core_dq_oe;

   e203_subsys_top u_subsys (
      .clk        (hfextclk),
      .rst_n      (core_rst_n),
      .pc_rtvec   (pc_rtvec),
      .dbg_mode   (dbg_mode),
      .rtc_tick   (rtc_tick),
      .wake_evt   (wake_evt),
      .jtag_tck   (jtag_s[2]),
      .jtag_tms   (jtag_s[1]),
      .jtag_tdi   (jtag_s[0]),
      .jtag_tdo   (core_tdo),
      .jtag_tdo_oe(core_tdo_oe),
      .gpioA_i    (gpioA_s),
      .gpioB_i    (gpioB_s),
      .gpioA_o    (core_gpioA_o),
      .gpioA_oe   (core_gpioA_oe),
      .gpioB_o    (core_gpioB_o),
      .gpioB_oe   (core_gpioB_oe),
      .qspi_sck   (core_sck),
      .qspi_cs_0  (core_cs),
      .qspi_dq_i  (dq_s),
      .qspi_dq_o  (core_dq_o),
      .qspi_dq_oe (core_dq_oe)
   );

   assign pad.hfxoscen                        = 1'b1;
   assign pad.lfxoscen                        = 1'b1;
   assign pad.io_pads_aon_pmu_padrst_o_oval   = ~core_rst_n;
   assign pad.io_pads_aon_pmu_vddpaden_o_oval = (pmu_st == PMU_ON);

   assign pad.io_pads_jtag_TDO_o_oval = tdo_q;
   assign pad.io_pads_jtag_TDO_o_oe   = tdo_oe_q;

   // Output enables and chip select are held safe combinationally while the core is in reset.
   assign pad.io_pads_gpioA_o_oval      = core_gpioA_o;
   assign pad.io_pads_gpioA_o_oe        = core_rst_n ? core_gpioA_oe : '0;
   assign pad.io_pads_gpioB_o_oval      = core_gpioB_o;
   assign pad.io_pads_gpioB_o_oe        = core_rst_n ? core_gpioB_oe : '0;
   assign pad.io_pads_qspi0_sck_o_oval  = core_rst_n & core_sck;
   assign pad.io_pads_qspi0_cs_0_o_oval = ~core_rst_n | core_cs;
   assign pad.io_pads_qspi0_dq_0_o_oval = core_dq_o[0];
   assign pad.io_pads_qspi0_dq_1_o_oval = core_dq_o[1];
   assign pad.io_pads_qspi0_dq_2_o_oval = core_dq_o[2];
   assign pad.io_pads_qspi0_dq_3_o_oval = core_dq_o[3];
   assign pad.io_pads_qspi0_dq_0_o_oe   = core_rst_n & core_dq_oe[0];
   assign pad.io_pads_qspi0_dq_1_o_oe   = core_rst_n & core_dq_oe[1];
   assign pad.io_pads_qspi0_dq_2_o_oe   = core_rst_n & core_dq_oe[2];
   assign pad.io_pads_qspi0_dq_3_o_oe   = core_rst_n & core_dq_oe[3];

endmodule

// File: tb/tb_e203_soc_pad_top.sv
// Directed bench for the E203 pad shell; one time unit = 100 ps, so hfextclk period 40 = 4 ns.
// Outputs are sampled on the falling clock edge (or just after an async reset change).
module tb_e203_soc_pad_top;

   logic hfextclk = 1'b0;
   logic erst_n;
   int   errors = 0;
   int   checks = 0;

   e203_soc_pad_top_if pad();

   e203_soc_pad_top dut (
      .hfextclk                 (hfextclk),
      .io_pads_aon_erst_n_i_ival(erst_n),
      .pad                      (pad.master)
   );

   initial forever #20 hfextclk = ~hfextclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // RTC tick monitor: counts pulses, widest pulse and spacing between pulse starts.
   logic mon_en = 1'b0;
   int   cyc = 0, tick_cnt = 0, run = 0, max_run = 0, last_tick = -1;
   int   min_gap = 1000, max_gap = 0;

   always @(negedge hfextclk) begin
      if (mon_en) begin
         cyc++;
         if (dut.rtc_tick) begin
            if (run == 0) begin
               tick_cnt++;
               if (last_tick >= 0) begin
                  if (cyc - last_tick < min_gap) min_gap = cyc - last_tick;
                  if (cyc - last_tick > max_gap) max_gap = cyc - last_tick;
               end
               last_tick = cyc;
            end
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   initial begin
      erst_n = 1'b0;
      pad.lfextclk = 1'b0;
      pad.io_pads_jtag_TCK_i_ival = 1'b0;
      pad.io_pads_jtag_TMS_i_ival = 1'b0;
      pad.io_pads_jtag_TDI_i_ival = 1'b0;
      pad.io_pads_gpioA_i_ival = '0;
      pad.io_pads_gpioB_i_ival = '0;
      pad.io_pads_qspi0_dq_0_i_ival = 1'b0;
      pad.io_pads_qspi0_dq_1_i_ival = 1'b0;
      pad.io_pads_qspi0_dq_2_i_ival = 1'b0;
      pad.io_pads_qspi0_dq_3_i_ival = 1'b0;
      pad.io_pads_aon_pmu_dwakeup_n_i_ival = 1'b1;
      pad.io_pads_bootrom_n_i_ival = 1'b0;
      pad.io_pads_dbgmode0_n_i_ival = 1'b1;
      pad.io_pads_dbgmode1_n_i_ival = 1'b1;
      pad.io_pads_dbgmode2_n_i_ival = 1'b1;

      // Reset state
      repeat (25) @(negedge hfextclk);
      chk("rst_osc", {pad.hfxoscen, pad.lfxoscen}, 32'h3);
      chk("rst_pmu", {pad.io_pads_aon_pmu_padrst_o_oval, pad.io_pads_aon_pmu_vddpaden_o_oval}, 32'h2);
      chk("rst_gpioA_oe", pad.io_pads_gpioA_o_oe, 32'h0);
      chk("rst_gpioB_oe", pad.io_pads_gpioB_o_oe, 32'h0);
      chk("rst_dq_oe", {pad.io_pads_qspi0_dq_3_o_oe, pad.io_pads_qspi0_dq_2_o_oe,
                        pad.io_pads_qspi0_dq_1_o_oe, pad.io_pads_qspi0_dq_0_o_oe}, 32'h0);
      chk("rst_tdo", {pad.io_pads_jtag_TDO_o_oval, pad.io_pads_jtag_TDO_o_oe}, 32'h0);
      chk("rst_cs_sck", {pad.io_pads_qspi0_cs_0_o_oval, pad.io_pads_qspi0_sck_o_oval}, 32'h2);
      chk("rst_dbg_tick", {dut.dbg_mode, dut.rtc_tick}, 32'h0);
      chk("rst_rtvec", dut.pc_rtvec, 32'h0000_1000);

      // Release at 120 ns; padrst drops two edges later, vddpaden one cycle after that
      repeat (5) @(negedge hfextclk);
      erst_n = 1'b1;
      @(negedge hfextclk);
      chk("rel_padrst_1edge", pad.io_pads_aon_pmu_padrst_o_oval, 32'h1);
      @(negedge hfextclk);
      chk("rel_pmu_2edge", {pad.io_pads_aon_pmu_padrst_o_oval, pad.io_pads_aon_pmu_vddpaden_o_oval}, 32'h0);
      @(negedge hfextclk);
      chk("rel_pmu_3edge", {pad.io_pads_aon_pmu_padrst_o_oval, pad.io_pads_aon_pmu_vddpaden_o_oval}, 32'h1);
      chk("rel_osc", {pad.hfxoscen, pad.lfxoscen}, 32'h3);
      chk("boot0_rtvec", dut.pc_rtvec, 32'h0000_1000);
      chk("boot0_dbg", dut.dbg_mode, 32'h0);

      // Strap change after capture is ignored
      pad.io_pads_bootrom_n_i_ival = 1'b1;
      pad.io_pads_dbgmode2_n_i_ival = 1'b0;
      pad.io_pads_dbgmode1_n_i_ival = 1'b1;
      pad.io_pads_dbgmode0_n_i_ival = 1'b0;
      repeat (3) @(negedge hfextclk);
      chk("strap_hold0_rtvec", dut.pc_rtvec, 32'h0000_1000);
      chk("strap_hold0_dbg", dut.dbg_mode, 32'h0);

      // GPIO input latency of two cycles, gpioB drive follows the core combinationally
      pad.io_pads_gpioA_i_ival = 32'hA5A5_0F0F;
      pad.io_pads_qspi0_dq_3_i_ival = 1'b1;
      pad.io_pads_qspi0_dq_1_i_ival = 1'b1;
      @(negedge hfextclk);
      chk("gpioA_lat1", pad.io_pads_gpioB_o_oe, 32'h0);
      @(negedge hfextclk);
      chk("gpioA_lat2_oe", pad.io_pads_gpioB_o_oe, 32'hA5A5_0F0F);
      chk("gpioA_lat2_oval", pad.io_pads_gpioB_o_oval, 32'h5A5A_F0F0);
      chk("dq_loop", {pad.io_pads_qspi0_dq_3_o_oval, pad.io_pads_qspi0_dq_2_o_oval,
                      pad.io_pads_qspi0_dq_1_o_oval, pad.io_pads_qspi0_dq_0_o_oval}, 32'hA);
      pad.io_pads_gpioA_i_ival = 32'hFFFF_0000;
      repeat (2) @(negedge hfextclk);
      chk("gpioB_oe_half", pad.io_pads_gpioB_o_oe, 32'hFFFF_0000);

      // TDO: core drives 1/1 after the synchroniser, pins one cycle later
      pad.io_pads_jtag_TDI_i_ival = 1'b1;
      pad.io_pads_jtag_TMS_i_ival = 1'b1;
      repeat (2) @(negedge hfextclk);
      chk("tdo_core_cycle", {pad.io_pads_jtag_TDO_o_oval, pad.io_pads_jtag_TDO_o_oe}, 32'h0);
      @(negedge hfextclk);
      chk("tdo_pin_cycle", {pad.io_pads_jtag_TDO_o_oval, pad.io_pads_jtag_TDO_o_oe}, 32'h3);

      // Wake pin low reaches the core two cycles later
      pad.io_pads_aon_pmu_dwakeup_n_i_ival = 1'b0;
      @(negedge hfextclk);
      chk("wake_1cyc", dut.wake_evt, 32'h0);
      @(negedge hfextclk);
      chk("wake_2cyc", dut.wake_evt, 32'h1);
      pad.io_pads_aon_pmu_dwakeup_n_i_ival = 1'b1;

      // All enables driven, then reset dropped between clock edges
      pad.io_pads_gpioA_i_ival = 32'hFFFF_FFFF;
      pad.io_pads_gpioB_i_ival = 32'hFFFF_FFFF;
      pad.io_pads_jtag_TCK_i_ival = 1'b1;
      repeat (3) @(negedge hfextclk);
      chk("run_gpioA_oe", pad.io_pads_gpioA_o_oe, 32'hFFFF_FFFF);
      chk("run_gpioB_oe", pad.io_pads_gpioB_o_oe, 32'hFFFF_FFFF);
      chk("run_ctl", {pad.io_pads_qspi0_dq_3_o_oe, pad.io_pads_qspi0_dq_2_o_oe,
                      pad.io_pads_qspi0_dq_1_o_oe, pad.io_pads_qspi0_dq_0_o_oe,
                      pad.io_pads_jtag_TDO_o_oe, pad.io_pads_qspi0_cs_0_o_oval,
                      pad.io_pads_qspi0_sck_o_oval}, 32'h7D);
      #5;
      erst_n = 1'b0;
      #1;
      chk("async_gpioA_oe", pad.io_pads_gpioA_o_oe, 32'h0);
      chk("async_gpioB_oe", pad.io_pads_gpioB_o_oe, 32'h0);
      chk("async_ctl", {pad.io_pads_qspi0_dq_3_o_oe, pad.io_pads_qspi0_dq_2_o_oe,
                        pad.io_pads_qspi0_dq_1_o_oe, pad.io_pads_qspi0_dq_0_o_oe,
                        pad.io_pads_jtag_TDO_o_oe, pad.io_pads_qspi0_cs_0_o_oval,
                        pad.io_pads_qspi0_sck_o_oval}, 32'h02);
      chk("async_pmu", {pad.io_pads_aon_pmu_padrst_o_oval, pad.io_pads_aon_pmu_vddpaden_o_oval}, 32'h2);
      chk("async_rtvec", dut.pc_rtvec, 32'h0000_1000);

      // Second boot with bootrom_n=1, dbgmode_n=3'b010
      repeat (2) @(negedge hfextclk);
      erst_n = 1'b1;
      repeat (3) @(negedge hfextclk);
      chk("boot1_rtvec", dut.pc_rtvec, 32'h2000_0000);
      chk("boot1_dbg", dut.dbg_mode, 32'h5);
      pad.io_pads_bootrom_n_i_ival = 1'b0;
      pad.io_pads_dbgmode2_n_i_ival = 1'b1;
      pad.io_pads_dbgmode0_n_i_ival = 1'b1;
      repeat (3) @(negedge hfextclk);
      chk("strap_hold1_rtvec", dut.pc_rtvec, 32'h2000_0000);
      chk("strap_hold1_dbg", dut.dbg_mode, 32'h5);

      // lfextclk toggling every 33 ns, phase chosen to stay clear of the sampling edge
      mon_en = 1'b1;
      @(negedge hfextclk);
      #5;
      for (int k = 0; k < 20; k++) begin
         pad.lfextclk = ~pad.lfextclk;
         #330;
      end
      repeat (4) @(negedge hfextclk);
      mon_en = 1'b0;
      chk("rtc_tick_count", tick_cnt, 32'd10);
      chk("rtc_tick_width", max_run, 32'd1);
      chk("rtc_min_gap", min_gap, 32'd16);
      chk("rtc_max_gap", max_gap, 32'd17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/e203_soc_pad_top.md
Name: e203_soc_pad_top

Overview:
Chip-level top shell of the E203 SoC, single clock domain (hfextclk).
- Conditions reset, latches boot/debug straps, turns lfextclk into a real-time tick, and synchronises or drives all pads.
- Instantiates the existing core subsystem e203_subsys_top and connects it to the pad ring.
- Everything beyond pad glue (CPU, ITCM/DTCM, PLIC, CLINT, peripherals) lives in e203_subsys_top.

Parameters:
SYNC_STAGES, 2, flop depth of every input synchroniser (min 2).
ROM_RTVEC, 32'h0000_1000, reset PC when bootrom_n=0.
XIP_RTVEC, 32'h2000_0000, reset PC when bootrom_n=1.
GPIO_W, 32, width of each GPIO bank.

Ports:
hfextclk  in  1  sole clock; all flops on its rising edge.
io_pads_aon_erst_n_i_ival  in  1  reset; asynchronous, active-low.
hfxoscen  out  1  HF oscillator enable.
lfextclk  in  1  slow reference, sampled as data (not a clock).
lfxoscen  out  1  LF oscillator enable.
io_pads_jtag_TCK_i_ival / TMS / TDI  in  1 each  JTAG pins.
io_pads_jtag_TDO_o_oval  out  1  JTAG data out.
io_pads_jtag_TDO_o_oe  out  1  TDO output enable.
io_pads_gpioA_i_ival / gpioB_i_ival  in  GPIO_W  GPIO inputs.
io_pads_gpioA_o_oval / o_oe, gpioB_o_oval / o_oe  out  GPIO_W  GPIO outputs and enables.
io_pads_qspi0_sck_o_oval  out  1  QSPI clock.
io_pads_qspi0_cs_0_o_oval  out  1  QSPI chip select.
io_pads_qspi0_dq_[0..3]_i_ival  in  1  QSPI data in.
io_pads_qspi0_dq_[0..3]_o_oval / o_oe  out  1  QSPI data out and enable.
io_pads_aon_pmu_dwakeup_n_i_ival  in  1  wake pin, active-low.
io_pads_aon_pmu_vddpaden_o_oval  out  1  pad-supply enable.
io_pads_aon_pmu_padrst_o_oval  out  1  pad reset, active-high.
io_pads_bootrom_n_i_ival  in  1  boot strap.
io_pads_dbgmode0_n_i_ival / dbgmode1_n / dbgmode2_n  in  1 each  debug straps, active-low.

Behaviour:
- Reset generation:
  - erst_n low asynchronously clears a SYNC_STAGES-deep shift chain.
  - The chain shifts in 1 each cycle; core_rst_n = last stage.
  - core_rst_n asserts immediately and deasserts SYNC_STAGES rising edges after erst_n rises.
  - erst_n dropping mid-operation: core_rst_n = 0 the same instant; all block state returns to reset values.
- Reset values:
  - hfxoscen = 1 and lfxoscen = 1 (constant, also in reset).
  - padrst = 1, vddpaden = 0.
  - All o_oe = 0, TDO_o_oval = 0, qspi cs = 1, sck = 0.
  - Straps = 0, rtc_tick = 0.
- PMU outputs:
  - padrst = ~core_rst_n.
  - vddpaden rises on the first cycle after core_rst_n = 1, then stays 1. There is no sleep mode.
  - dwakeup_n is synchronised, inverted and forwarded to the core as wake_evt (level).
- Straps:
  - bootrom_n and dbgmode*_n are captured on the edge where core_rst_n first reads 1, then held until the next reset.
  - pc_rtvec = bootrom_n ? XIP_RTVEC : ROM_RTVEC.
  - dbg_mode[2:0] = ~{dbgmode2_n, dbgmode1_n, dbgmode0_n}.
- RTC tick:
  - lfextclk passes through the synchroniser, then a rising-edge detect.
  - rtc_tick is a 1-cycle pulse per lfextclk rising edge; no tick is generated on falling edges.
  - Glitches shorter than one hfextclk period are not guaranteed.
- Input pads:
  - JTAG TCK/TMS/TDI, gpioA/B inputs and qspi dq inputs each pass through a SYNC_STAGES synchroniser before the core.
  - Latency is SYNC_STAGES cycles.
- Output pads:
  - TDO_o_oval and TDO_o_oe are registered (1-cycle latency).
  - GPIO, QSPI and their oe are combinational from the core.
  - While core_rst_n = 0, every oe is forced to 0 and cs is forced to 1.
- Simultaneous events: reset has priority over everything; a strap change after capture is ignored.

Decomposition:
- Shared package e203_soc_pkg holds ROM_RTVEC, XIP_RTVEC, GPIO_W and the dbg_mode encoding.
- One generic sub-module, e203_gnrl_sync (width-parameterised N-stage synchroniser with async active-low reset), is reused for all inputs.
- e203_subsys_top is instantiated unmodified. Its connections are core_rst_n, pc_rtvec, dbg_mode, rtc_tick, wake_evt, and the synchronised and raw pad buses.

Test Plan:
1. erst_n = 0 at t=0, released at 120 ns (clk period 4 ns) -> padrst = 1 until 2 edges after release, then 0; vddpaden 0->1 one cycle later; hfxoscen = lfxoscen = 1 throughout.
2. bootrom_n = 0, dbgmode*_n = 1 at release -> pc_rtvec = 0x0000_1000, dbg_mode = 3'b000. Repeat with bootrom_n = 1, dbgmode = 3'b010 -> pc_rtvec = 0x2000_0000, dbg_mode = 3'b101. Toggling the straps afterwards leaves both values unchanged.
3. lfextclk toggling every 33 ns -> exactly one rtc_tick pulse per 66 ns period (16-17 cycle spacing), none on falling edges.
4. gpioA_i = 32'hA5A5_0F0F applied -> core sees the value after exactly 2 cycles; core drives gpioB oe = 32'hFFFF_0000 -> pad oe follows combinationally.
5. Assert erst_n low mid-run with core driving all oe = 1 -> all oe = 0, cs = 1, padrst = 1 immediately (no clock edge needed).
6. Core tdo/tdo_oe = 1/1 -> TDO pad pins show 1/1 one cycle later; dwakeup_n pulse low -> wake_evt = 1 two cycles later.
